// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM receive demultiplexer.
// Frame geometry, FSM state encoding and the even-parity helper live here.
package tdm_pkg;

  localparam int LANES       = 8;
  localparam int SEL_W       = 3;
  localparam int CNT_W       = 4;
  localparam int PARITY_SLOT = 8;

  typedef logic [LANES-1:0] frame_t;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Reduction XOR: 1'b1 when the frame holds an odd number of ones.
  function automatic logic even_par(input frame_t f);
    return ^f;
  endfunction

endpackage

// File: rtl/tdm_demux1to8_if.sv
// Serial-in / parallel-out bundle of the TDM receiver.
// The transmitter-side driver uses master; the demultiplexer uses slave.
interface tdm_demux1to8_if;
  import tdm_pkg::*;

  logic               din;
  logic               din_valid;
  logic               frame_start;
  frame_t             dout;
  logic               dout_valid;
  logic [SEL_W-1:0]   slot;
  logic               sync_err;
  logic               parity_err;

  modport master (
    output din, din_valid, frame_start,
    input  dout, dout_valid, slot, sync_err, parity_err
  );

  modport slave (
    input  din, din_valid, frame_start,
    output dout, dout_valid, slot, sync_err, parity_err
  );

endinterface

// File: rtl/tdm_demux1to8_demux1to2.sv
// Combinational 1-to-2 steering cell: routes d onto y[s], the other leg is 0.
// Chained in a binary tree to decode the slot index into lane write enables.
module demux1to2 (
  input  logic       d,
  input  logic       s,
  output logic [1:0] y
);

  assign y[0] = d & ~s;
  assign y[1] = d &  s;

endmodule

// File: rtl/tdm_demux1to8.sv
// 8-lane TDM receive demultiplexer: serial slots -> registered parallel frame.
// Define TDM_PARITY_CHECK_EN to append an even-parity slot (9-slot frames).
module tdm_demux1to8 (
  input  logic            clk,
  input  logic            rst_n,
  tdm_demux1to8_if.slave  bus
);
  import tdm_pkg::*;

`ifdef TDM_PARITY_CHECK_EN
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(PARITY_SLOT);
`else
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(LANES - 1);
`endif
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  frame_t            shadow_r, shadow_base_s, shadow_nxt_s;
  frame_t            dout_r, dout_nxt_s;
  logic              dout_valid_r, dout_valid_nxt_s;
  logic              sync_err_r, sync_err_nxt_s;
`ifdef TDM_PARITY_CHECK_EN
  logic              parity_err_r, parity_err_nxt_s;
`endif
  logic              wr_en_s;
  logic [SEL_W-1:0]  wr_slot_s;
  logic [1:0]        lvl1_s;
  logic [3:0]        lvl2_s;
  logic [LANES-1:0]  lane_en_s;

  // Lane-enable decode tree: slot MSB at the root, LSB at the leaves.
  demux1to2 u_lvl0 (
    .d (wr_en_s),
    .s (wr_slot_s[2]),
    .y (lvl1_s)
  );

  for (genvar g = 0; g < 2; g++) begin : g_lvl1
    demux1to2 u_cell (
      .d (lvl1_s[g]),
      .s (wr_slot_s[1]),
      .y (lvl2_s[2*g+1:2*g])
    );
  end

  for (genvar g = 0; g < 4; g++) begin : g_lvl2
    demux1to2 u_cell (
      .d (lvl2_s[g]),
      .s (wr_slot_s[0]),
      .y (lane_en_s[2*g+1:2*g])
    );
  end

  // Next-state, slot counter and output strobes for the receive FSM.
  always_comb begin
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r;
    shadow_base_s    = shadow_r;
    dout_nxt_s       = dout_r;
    dout_valid_nxt_s = 1'b0;
    sync_err_nxt_s   = 1'b0;
`ifdef TDM_PARITY_CHECK_EN
    parity_err_nxt_s = 1'b0;
`endif
    wr_en_s          = 1'b0;
    wr_slot_s        = cnt_r[SEL_W-1:0];

    case (state_r)
      IDLE: begin
        if (bus.din_valid && bus.frame_start) begin
          shadow_base_s = {LANES{1'b0}};
          wr_slot_s     = {SEL_W{1'b0}};
          wr_en_s       = 1'b1;
          cnt_nxt_s     = CNT_ONE;
          state_nxt_s   = COLLECT;
        end else begin
          state_nxt_s   = IDLE;
        end
      end
      COLLECT: begin
        if (!bus.din_valid) begin
          state_nxt_s = COLLECT;
        end else if (bus.frame_start) begin
          // Misaligned start, including one on the final slot: restart here.
          sync_err_nxt_s = 1'b1;
          shadow_base_s  = {LANES{1'b0}};
          wr_slot_s      = {SEL_W{1'b0}};
          wr_en_s        = 1'b1;
          cnt_nxt_s      = CNT_ONE;
        end else if (cnt_r == LAST_SLOT) begin
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = IDLE;
`ifdef TDM_PARITY_CHECK_EN
          if ((even_par(shadow_r) ^ bus.din) == 1'b0) begin
            dout_nxt_s       = shadow_r;
            dout_valid_nxt_s = 1'b1;
          end else begin
            parity_err_nxt_s = 1'b1;
          end
`else
          // Last data lane bypasses the shadow so the frame lands this edge.
          wr_en_s                 = 1'b1;
          dout_nxt_s              = shadow_r;
          dout_nxt_s[LANES-1]     = bus.din;
          dout_valid_nxt_s        = 1'b1;
`endif
        end else begin
          wr_en_s   = 1'b1;
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Shadow write-back: each enabled lane captures the current serial bit.
  always_comb begin
    shadow_nxt_s = shadow_base_s;
    for (int k = 0; k < LANES; k++) begin
      if (lane_en_s[k]) begin
        shadow_nxt_s[k] = bus.din;
      end else begin
        shadow_nxt_s[k] = shadow_base_s[k];
      end
    end
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_ZERO;
      shadow_r     <= {LANES{1'b0}};
      dout_r       <= {LANES{1'b0}};
      dout_valid_r <= 1'b0;
      sync_err_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      shadow_r     <= shadow_nxt_s;
      dout_r       <= dout_nxt_s;
      dout_valid_r <= dout_valid_nxt_s;
      sync_err_r   <= sync_err_nxt_s;
    end
  end

`ifdef TDM_PARITY_CHECK_EN
  // Parity failure strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_r <= 1'b0;
    end else begin
      parity_err_r <= parity_err_nxt_s;
    end
  end

  assign bus.parity_err = parity_err_r;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.sync_err   = sync_err_r;
  assign bus.slot       = cnt_r[SEL_W-1:0];

endmodule

// File: tb/tb_tdm_demux1to8.sv
// Scoreboard bench for tdm_demux1to8: the driver queues expected frames and
// error strobes with their due cycle; a negedge monitor checks every cycle.
module tb_tdm_demux1to8;
  import tdm_pkg::*;

`ifdef TDM_PARITY_CHECK_EN
  localparam int NSLOTS = LANES + 1;
`else
  localparam int NSLOTS = LANES;
`endif

  typedef struct {
    frame_t data;
    int     cyc;
  } exp_t;

  logic   clk;
  logic   rst_n;
  int     cyc;
  int     n_cmp;
  int     n_err;
  frame_t model_dout;
  exp_t   exp_q[$];
  int     sync_q[$];
  int     par_q[$];

  tdm_demux1to8_if bus ();

  tdm_demux1to8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Monitor: compares every output on every falling edge against the model.
  always @(negedge clk) begin
    bit exp_v, exp_s, exp_p;
    if (!rst_n) begin
      model_dout = 8'h00;
      check("rst_dout", 32'(bus.dout), 32'h0);
      check("rst_dout_valid", 32'(bus.dout_valid), 32'h0);
      check("rst_sync_err", 32'(bus.sync_err), 32'h0);
      check("rst_parity_err", 32'(bus.parity_err), 32'h0);
      check("rst_slot", 32'(bus.slot), 32'h0);
    end else begin
      exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      if (exp_v) begin
        model_dout = exp_q[0].data;
        void'(exp_q.pop_front());
      end
      exp_s = (sync_q.size() > 0) && (sync_q[0] == cyc);
      if (exp_s) void'(sync_q.pop_front());
      exp_p = (par_q.size() > 0) && (par_q[0] == cyc);
      if (exp_p) void'(par_q.pop_front());
      check("dout_valid", 32'(bus.dout_valid), 32'(exp_v));
      check("dout", 32'(bus.dout), 32'(model_dout));
      check("sync_err", 32'(bus.sync_err), 32'(exp_s));
      check("parity_err", 32'(bus.parity_err), 32'(exp_p));
    end
  end

  task automatic send_beat(input logic d, input logic fs);
    @(posedge clk);
    #1;
    bus.din         = d;
    bus.din_valid   = 1'b1;
    bus.frame_start = fs;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    bus.din         = 1'b0;
    bus.din_valid   = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  function automatic logic slot_bit(input frame_t f, input int k, input bit par_flip);
    if (k < LANES) return f[k];
    return (^f) ^ par_flip;
  endfunction

  // Sends a whole frame; gap_len idle cycles follow slot gap_at.
  task automatic send_frame(input frame_t f, input int gap_at, input int gap_len,
                            input bit resync, input bit par_flip);
    exp_t e;
    for (int k = 0; k < NSLOTS; k++) begin
      send_beat(slot_bit(f, k, par_flip), (k == 0));
      if (k == 0 && resync) sync_q.push_back(cyc + 1);
      if (k == NSLOTS - 1) begin
        if (par_flip) begin
          par_q.push_back(cyc + 1);
        end else begin
          e.data = f;
          e.cyc  = cyc + 1;
          exp_q.push_back(e);
        end
      end
      if (k == gap_at) repeat (gap_len) idle_cycle();
    end
  endtask

  task automatic send_partial(input frame_t f, input int nbeats);
    for (int k = 0; k < nbeats; k++) send_beat(slot_bit(f, k, 1'b0), (k == 0));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    model_dout = 8'h00;
    bus.din = 1'b0;
    bus.din_valid = 1'b0;
    bus.frame_start = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Stray beats without frame_start are dropped while idle.
    send_beat(1'b1, 1'b0);
    send_beat(1'b1, 1'b0);
    send_beat(1'b1, 1'b0);

    // Plain frame, then the same frame with a 3-cycle gap after slot 3.
    send_frame(8'hBB, -1, 0, 1'b0, 1'b0);
    repeat (2) idle_cycle();
    @(negedge clk);
    check("slot_after_frame", 32'(bus.slot), 32'h0);
    send_frame(8'hBB, 3, 3, 1'b0, 1'b0);
    repeat (2) idle_cycle();

    // Resync at slot 5 of 8'h5A; only 8'hC3 comes out.
    send_partial(8'h5A, 5);
    send_frame(8'hC3, -1, 0, 1'b1, 1'b0);
    repeat (2) idle_cycle();

    // frame_start on the very last slot also breaks the frame.
    send_partial(8'h66, NSLOTS - 1);
    send_frame(8'h99, -1, 0, 1'b1, 1'b0);
    repeat (2) idle_cycle();

    // Back-to-back frames at full throughput.
    send_frame(8'hFF, -1, 0, 1'b0, 1'b0);
    send_frame(8'h00, -1, 0, 1'b0, 1'b0);
    send_frame(8'h81, -1, 0, 1'b0, 1'b0);
    repeat (2) idle_cycle();

    // Reset in the middle of frame 8'hA5, then frame 8'h3C.
    send_partial(8'hA5, 4);
    idle_cycle();
    @(negedge clk);
    check("slot_mid_frame", 32'(bus.slot), 32'h4);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_dout", 32'(bus.dout), 32'h0);
    check("async_rst_slot", 32'(bus.slot), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_frame(8'h3C, -1, 0, 1'b0, 1'b0);
    repeat (2) idle_cycle();
    @(negedge clk);
    check("dout_after_rst", 32'(bus.dout), 32'h3C);

`ifdef TDM_PARITY_CHECK_EN
    // Good parity delivers; bad parity keeps the previous word.
    send_frame(8'hBB, -1, 0, 1'b0, 1'b0);
    repeat (2) idle_cycle();
    send_frame(8'hBB, -1, 0, 1'b0, 1'b1);
    repeat (2) idle_cycle();
    send_frame(8'h3C, -1, 0, 1'b0, 1'b1);
    repeat (2) idle_cycle();
    @(negedge clk);
    check("dout_hold_on_par", 32'(bus.dout), 32'hBB);
`endif

    repeat (4) idle_cycle();
    @(negedge clk);
    check("exp_q_left", 32'(exp_q.size()), 32'h0);
    check("sync_q_left", 32'(sync_q.size()), 32'h0);
    check("par_q_left", 32'(par_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
